mulshift_seq: RTL



---
 rtl/mulshift_pkg.sv | 51 +++++
 rtl/mul16x16.sv | 15 +
 rtl/mulshift_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mulshift_pkg.sv
// Shared types and constants for the multiply/shift sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mulshift_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;
  localparam int ACC_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_SHL   = 2'b01,
    OP_MULHU = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_e;

  // Effective multiplier halves {bh_e, bl_e}. SHL turns the shift amount into a
  // one-hot power of two placed in the low or high half depending on b[4].
  function automatic logic [DATA_W-1:0] eff_mult(input op_e o, input logic [DATA_W-1:0] bv);
    logic [HALF_W-1:0] oh;
    logic [DATA_W-1:0] r;
    oh = 16'h0001 << bv[3:0];
    r  = bv;
    if (o == OP_SHL) begin
      if (bv[4]) r = {oh, 16'h0000};
      else       r = {16'h0000, oh};
    end
    return r;
  endfunction

  // Final result word taken from the accumulator for each operation.
  function automatic logic [DATA_W-1:0] sel_result(input op_e o, input logic [ACC_W-1:0] acc_v);
    logic [DATA_W-1:0] r;
    case (o)
      OP_MUL, OP_SHL: r = acc_v[DATA_W-1:0];
      OP_MULHU:       r = acc_v[ACC_W-1:DATA_W];
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul16x16.sv
// Purely combinational 16x16 -> 32 unsigned multiplier.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller sequences the operands.
module mul16x16
  import mulshift_pkg::*;
(
  input  logic [HALF_W-1:0] x,
  input  logic [HALF_W-1:0] y,
  output logic [DATA_W-1:0] p
);

  // Full-width unsigned product; the 32-bit context keeps every bit.
  assign p = DATA_W'(x) * DATA_W'(y);

endmodule

// File: rtl/mulshift_seq.sv
// 32-bit MUL / SHL / MULHU sequenced over one shared 16x16 multiplier in four passes.
// Latency: 4 cycles from accept edge to out_valid; one op per 6 cycles at full rate.
// Backpressure: in_ready only in IDLE; result and accumulator hold in DONE until out_ready.
module mulshift_seq
  import mulshift_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  state_e            state;
  op_e               op_q;
  logic [DATA_W-1:0] a_q;
  logic [HALF_W-1:0] bl_q;
  logic [HALF_W-1:0] bh_q;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] result_q;

  logic [HALF_W-1:0] mul_x;
  logic [HALF_W-1:0] mul_y;
  logic [DATA_W-1:0] prod;
  logic [ACC_W-1:0]  acc_add;
  logic [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0] eff_b;

  // Multiplier decode happens here, before the operand registers, so the
  // P-state datapath only sees registered halves.
  assign eff_b = eff_mult(op_e'(op), b);

  // Select the operand halves for the current pass.
  always_comb begin
    mul_x = a_q[HALF_W-1:0];
    mul_y = bl_q;
    case (state)
      P0: begin mul_x = a_q[HALF_W-1:0];      mul_y = bl_q; end
      P1: begin mul_x = a_q[HALF_W-1:0];      mul_y = bh_q; end
      P2: begin mul_x = a_q[DATA_W-1:HALF_W]; mul_y = bl_q; end
      P3: begin mul_x = a_q[DATA_W-1:HALF_W]; mul_y = bh_q; end
      default: begin mul_x = a_q[HALF_W-1:0]; mul_y = bl_q; end
    endcase
  end

  mul16x16 u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (prod)
  );

  // Align the partial product to its weight for the current pass.
  always_comb begin
    acc_add = '0;
    case (state)
      P0:      acc_add = {32'h0, prod};
      P1, P2:  acc_add = {16'h0, prod, 16'h0};
      P3:      acc_add = {prod, 32'h0};
      default: acc_add = '0;
    endcase
  end

  assign acc_next = acc + acc_add;

  // Sequencer: accept in IDLE, four accumulate passes, hold result in DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      bl_q     <= '0;
      bh_q     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op_e'(op);
            a_q   <= a;
            bl_q  <= eff_b[HALF_W-1:0];
            bh_q  <= eff_b[DATA_W-1:HALF_W];
            acc   <= '0;
            state <= P0;
          end
        end
        P0: begin
          acc   <= acc_next;
          state <= P1;
        end
        P1: begin
          acc   <= acc_next;
          state <= P2;
        end
        P2: begin
          acc   <= acc_next;
          state <= P3;
        end
        P3: begin
          // The result register loads from the final sum so it is valid
          // on the same edge that out_valid rises.
          acc      <= acc_next;
          result_q <= sel_result(op_q, acc_next);
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;

endmodule
